ppu_cfg_sequencer: RTL and testbench



---
 rtl/ppu_cfg_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ppu_cfg_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_cfg_sequencer.sv
// ppu_cfg_sequencer
//
// Frame-synchronous configuration sequencer for the PPU post-processing chain.
// A requested tx-side datapath configuration word is never applied mid-frame.
// The sequencer first mutes the output stage, then commits the word on a
// vertical sync boundary, and keeps the output muted for SETTLE_FRAMES further
// vsync events. This lets the line multiplier and colour converter re-lock
// before video is shown again. If vsync disappears, a synthetic event is
// generated after VS_TIMEOUT cycles, so a configuration change cannot stall
// forever.
//
// Ports (VCLK_Tx domain):
//   VCLK           clock
//   nVRST_Tx       asynchronous active-low reset
//   vdata_valid_i  qualifies sync_i samples
//   sync_i         {nVSYNC, nCLAMP, nHSYNC, nCSYNC}; only bit 3 (nVSYNC) is used
//   cfg_req_i      requested configuration word (already resynchronised)
//   cfg_applied_o  configuration driven into the datapath
//   mute_o         1 = output stage forces blank/black
//   busy_o         1 = sequencer not idle
//   vsync_lost_o   1 = most recent vsync event was synthetic (timeout)
//
// All outputs come straight from flops.

module ppu_cfg_sequencer #(
    parameter int unsigned      CFG_W         = 21,
    parameter logic [CFG_W-1:0] CFG_RESET     = '0,
    parameter int unsigned      SETTLE_FRAMES = 2,
    parameter int unsigned      VS_TIMEOUT    = 1048575
) (
    input  logic             VCLK,
    input  logic             nVRST_Tx,
    input  logic             vdata_valid_i,
    input  logic [3:0]       sync_i,
    input  logic [CFG_W-1:0] cfg_req_i,
    output logic [CFG_W-1:0] cfg_applied_o,
    output logic             mute_o,
    output logic             busy_o,
    output logic             vsync_lost_o
);

    localparam int unsigned SC_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
    localparam int unsigned TO_W = (VS_TIMEOUT > 0) ? $clog2(VS_TIMEOUT + 1) : 1;

    localparam logic [SC_W-1:0] SETTLE_INIT = SC_W'(SETTLE_FRAMES);
    localparam logic [TO_W-1:0] TO_LIMIT    = TO_W'(VS_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StWaitVs,
        StSettle
    } state_e;

    state_e           state_q, state_d;
    logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             vs_prev_q, vs_prev_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             mute_q, mute_d;
    logic             busy_q, busy_d;
    logic             lost_q, lost_d;

    logic vs_ev;
    logic to_hit;
    logic syn_ev;
    logic ev;
    logic cfg_diff;

    // ------------------------------------------------------------------
    // Vsync event detection and timeout
    // ------------------------------------------------------------------

    // Falling edge of nVSYNC, judged only on qualified samples.
    assign vs_ev  = vdata_valid_i & ~sync_i[3] & vs_prev_q;
    assign to_hit = (to_cnt_q == TO_LIMIT);
    // A real edge arriving on the timeout cycle wins: one event, not synthetic.
    assign syn_ev = to_hit & ~vs_ev;
    assign ev     = vs_ev | to_hit;

    assign cfg_diff = (cfg_req_i != cfg_q);

    always_comb begin
        vs_prev_d = vs_prev_q;
        if (vdata_valid_i) begin
            vs_prev_d = sync_i[3];
        end
    end

    // The timeout only runs while a change is pending or settling; IDLE
    // keeps it cleared so the first wait always gets the full budget.
    always_comb begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (vs_ev || to_hit || (state_q == StIdle)) begin
            to_cnt_d = '0;
        end
    end

    always_comb begin
        lost_d = lost_q;
        if (vs_ev) begin
            lost_d = 1'b0;
        end else if (syn_ev) begin
            lost_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        cfg_d        = cfg_q;

        case (state_q)
            StIdle: begin
                if (cfg_diff) begin
                    state_d = StWaitVs;
                end
            end

            // Requests may keep changing here; whatever is presented on the
            // event cycle is what gets committed.
            StWaitVs: begin
                if (ev) begin
                    cfg_d        = cfg_req_i;
                    settle_cnt_d = SETTLE_INIT;
                    state_d      = StSettle;
                end
            end

            // A new request restarts the whole sequence, even on an event cycle.
            StSettle: begin
                if (cfg_diff) begin
                    state_d = StWaitVs;
                end else if (ev) begin
                    if (settle_cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        settle_cnt_d = settle_cnt_q - SC_W'(1);
                    end
                end
            end

            default: begin
                state_d = StSettle;
            end
        endcase

        // Registered from next state so mute asserts the cycle after a
        // request is seen and drops the cycle after the final event.
        mute_d = (state_d != StIdle);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge VCLK or negedge nVRST_Tx) begin
        if (!nVRST_Tx) begin
            state_q      <= StSettle;
            settle_cnt_q <= SETTLE_INIT;
            to_cnt_q     <= '0;
            vs_prev_q    <= 1'b1;
            cfg_q        <= CFG_RESET;
            mute_q       <= 1'b1;
            busy_q       <= 1'b1;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            to_cnt_q     <= to_cnt_d;
            vs_prev_q    <= vs_prev_d;
            cfg_q        <= cfg_d;
            mute_q       <= mute_d;
            busy_q       <= busy_d;
            lost_q       <= lost_d;
        end
    end

    assign cfg_applied_o = cfg_q;
    assign mute_o        = mute_q;
    assign busy_o        = busy_q;
    assign vsync_lost_o  = lost_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------

    // The datapath configuration may only move on a commit out of WAIT_VS.
    a_cfg_only_on_commit : assert property (
        @(posedge VCLK) disable iff (!nVRST_Tx)
        (cfg_q != $past(cfg_q)) |-> ($past(state_q) == StWaitVs)
    );

    // Whenever a new configuration is on the datapath, video must be muted.
    a_muted_while_applying : assert property (
        @(posedge VCLK) disable iff (!nVRST_Tx)
        (cfg_q != $past(cfg_q)) |-> mute_q
    );

endmodule

// File: tb/tb_ppu_cfg_sequencer.sv
// Bench for ppu_cfg_sequencer: scripted vector table with hand-derived
// expectations, hand-written corner sequences (async reset, vsync/timeout
// collision), then randomized traffic against a frame-level reference model.

module tb_ppu_cfg_sequencer;

    localparam int CFG_W     = 8;
    localparam int SETTLE    = 2;
    localparam int VS_TO     = 100;
    localparam int VS_PERIOD = 40;
    localparam int VS_LOW    = 4;

    logic             VCLK = 1'b0;
    logic             nVRST_Tx;
    logic             vdata_valid_i;
    logic [3:0]       sync_i;
    logic [CFG_W-1:0] cfg_req_i;
    logic [CFG_W-1:0] cfg_applied_o;
    logic             mute_o;
    logic             busy_o;
    logic             vsync_lost_o;

    always #5 VCLK = ~VCLK;

    ppu_cfg_sequencer #(
        .CFG_W         (CFG_W),
        .CFG_RESET     (8'h00),
        .SETTLE_FRAMES (SETTLE),
        .VS_TIMEOUT    (VS_TO)
    ) dut (
        .VCLK          (VCLK),
        .nVRST_Tx      (nVRST_Tx),
        .vdata_valid_i (vdata_valid_i),
        .sync_i        (sync_i),
        .cfg_req_i     (cfg_req_i),
        .cfg_applied_o (cfg_applied_o),
        .mute_o        (mute_o),
        .busy_o        (busy_o),
        .vsync_lost_o  (vsync_lost_o)
    );

    int       n_checks = 0;
    int       n_errors = 0;
    int       cyc = 0;
    int       vcnt = 0;
    bit       vs_en = 1'b1;
    bit       force_low = 1'b0;
    bit       seen_07 = 1'b0;
    logic [2:0] sync_lo = 3'b111;

    // ------------------------------------------------------------------
    // Reference model: tracks the phase of the change protocol, how many
    // more frames must pass muted, and the cycle at which the current
    // silence window began.
    // ------------------------------------------------------------------
    typedef enum int {MIdle, MWait, MSettle} mphase_e;

    mphase_e    m_phase;
    int         m_frames;
    int         m_anchor;
    bit         m_lost;
    logic [7:0] m_applied;
    bit         m_vs_hi;

    task automatic model_reset();
        m_phase   = MSettle;
        m_frames  = SETTLE;
        m_anchor  = cyc + 1;
        m_lost    = 1'b0;
        m_applied = 8'h00;
        m_vs_hi   = 1'b1;
    endtask

    task automatic model_step(input bit vv, input bit s3, input logic [7:0] req);
        bit real_ev;
        bit timeout;
        bit ev;
        real_ev = vv && !s3 && m_vs_hi;
        timeout = ((cyc - m_anchor) == VS_TO);
        ev      = real_ev || timeout;
        if (real_ev) m_lost = 1'b0;
        else if (timeout) m_lost = 1'b1;
        if (ev || m_phase == MIdle) m_anchor = cyc + 1;
        if (vv) m_vs_hi = s3;
        case (m_phase)
            MIdle: if (req != m_applied) m_phase = MWait;
            MWait: begin
                if (ev) begin
                    m_applied = req;
                    m_frames  = SETTLE;
                    m_phase   = MSettle;
                end
            end
            MSettle: begin
                if (req != m_applied) begin
                    m_phase = MWait;
                end else if (ev) begin
                    if (m_frames == 0) m_phase = MIdle;
                    else m_frames--;
                end
            end
            default: m_phase = MSettle;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive vsync pattern, advance model at the edge, compare after it.
    task automatic tick();
        bit s3;
        s3 = 1'b1;
        if (force_low) s3 = 1'b0;
        else if (vs_en && (vcnt % VS_PERIOD) >= VS_PERIOD - VS_LOW) s3 = 1'b0;
        sync_i = {s3, sync_lo};
        @(posedge VCLK);
        cyc++;
        model_step(vdata_valid_i, s3, cfg_req_i);
        #1;
        check("model cfg_applied", cfg_applied_o, m_applied);
        check("model mute", mute_o, m_phase != MIdle);
        check("model busy", busy_o, m_phase != MIdle);
        check("model vsync_lost", vsync_lost_o, m_lost);
        if (cfg_applied_o == 8'h07) seen_07 = 1'b1;
        if (vs_en) vcnt++;
    endtask

    task automatic startup_check(input string tag);
        repeat (116) tick();
        check({tag, " still muted before 3rd fall"}, mute_o, 1'b1);
        check({tag, " cfg held"}, cfg_applied_o, 8'h00);
        tick();
        check({tag, " unmuted after 3rd fall"}, mute_o, 1'b0);
        check({tag, " idle"}, busy_o, 1'b0);
        check({tag, " cfg after startup"}, cfg_applied_o, 8'h00);
    endtask

    typedef struct {
        logic [7:0] req;
        bit         vs;
        int         n;
        logic [7:0] e_app;
        bit         e_mute;
        bit         e_lost;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] req, input bit vs, input int n,
                       input logic [7:0] e_app, input bit e_mute, input bit e_lost);
        vec_t v;
        v.req = req; v.vs = vs; v.n = n;
        v.e_app = e_app; v.e_mute = e_mute; v.e_lost = e_lost;
        vq.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        nVRST_Tx      = 1'b1;
        vdata_valid_i = 1'b1;
        sync_i        = 4'hF;
        cfg_req_i     = 8'h00;
        #2 nVRST_Tx = 1'b0;
        #1;
        check("reset cfg_applied", cfg_applied_o, 8'h00);
        check("reset mute", mute_o, 1'b1);
        check("reset busy", busy_o, 1'b1);
        check("reset vsync_lost", vsync_lost_o, 1'b0);
        repeat (2) @(posedge VCLK);
        #2 nVRST_Tx = 1'b1;
        model_reset();

        // Startup: three vsync falls (vcnt 36, 76, 116) before unmute.
        startup_check("startup");

        // Scripted scenario; vcnt=117 here, falls at vcnt % 40 == 36.
        add(8'h00, 1,  20, 8'h00, 0, 0);  // idle filler to mid-frame
        add(8'h05, 1,   1, 8'h00, 1, 0);  // change in IDLE mutes next cycle
        add(8'h05, 1,  18, 8'h00, 1, 0);  // waiting for fall at 156
        add(8'h05, 1,   1, 8'h05, 1, 0);  // commit one cycle after fall
        add(8'h05, 1, 119, 8'h05, 1, 0);  // settle across falls 196, 236
        add(8'h05, 1,   1, 8'h05, 0, 0);  // unmute on fall 276
        add(8'h05, 1,  20, 8'h05, 0, 0);
        add(8'h07, 1,   5, 8'h05, 1, 0);  // change during WAIT_VS ...
        add(8'h09, 1,  14, 8'h05, 1, 0);  // ... superseded before fall 316
        add(8'h09, 1,   1, 8'h09, 1, 0);
        add(8'h09, 1,  30, 8'h09, 1, 0);
        add(8'h0A, 1,   1, 8'h09, 1, 0);  // change during SETTLE restarts
        add(8'h0A, 1,   8, 8'h09, 1, 0);
        add(8'h0A, 1,   1, 8'h0A, 1, 0);  // commit on fall 356
        add(8'h0A, 1, 119, 8'h0A, 1, 0);  // full settle re-runs
        add(8'h0A, 1,   1, 8'h0A, 0, 0);  // unmute on fall 476
        add(8'h0A, 0,   5, 8'h0A, 0, 0);  // vsync stops
        add(8'h11, 0, 101, 8'h0A, 1, 0);
        add(8'h11, 0,   1, 8'h11, 1, 1);  // synthetic commit
        add(8'h11, 0, 101, 8'h11, 1, 1);  // one synthetic settle step
        add(8'h11, 1,  36, 8'h11, 1, 1);  // vsync restored at frame start
        add(8'h11, 1,   1, 8'h11, 1, 0);  // first real fall clears lost
        add(8'h11, 1,  39, 8'h11, 1, 0);
        add(8'h11, 1,   1, 8'h11, 0, 0);

        foreach (vq[i]) begin
            if (vq[i].vs && !vs_en) vcnt = ((vcnt + VS_PERIOD - 1) / VS_PERIOD) * VS_PERIOD;
            vs_en     = vq[i].vs;
            cfg_req_i = vq[i].req;
            repeat (vq[i].n) tick();
            check($sformatf("vec%0d cfg_applied", i), cfg_applied_o, vq[i].e_app);
            check($sformatf("vec%0d mute", i), mute_o, vq[i].e_mute);
            check($sformatf("vec%0d busy", i), busy_o, vq[i].e_mute);
            check($sformatf("vec%0d vsync_lost", i), vsync_lost_o, vq[i].e_lost);
        end
        check("superseded 0x07 never applied", seen_07, 1'b0);

        // Reset mid-SETTLE with vsync_lost set: async return to reset values.
        vs_en     = 1'b0;
        cfg_req_i = 8'h22;
        repeat (105) tick();
        check("pre-reset vsync_lost", vsync_lost_o, 1'b1);
        check("pre-reset cfg_applied", cfg_applied_o, 8'h22);
        #3 nVRST_Tx = 1'b0;
        #1;
        check("async reset cfg_applied", cfg_applied_o, 8'h00);
        check("async reset mute", mute_o, 1'b1);
        check("async reset busy", busy_o, 1'b1);
        check("async reset vsync_lost", vsync_lost_o, 1'b0);
        @(posedge VCLK);
        #2;
        cfg_req_i = 8'h00;
        nVRST_Tx  = 1'b1;
        model_reset();
        vcnt  = 0;
        vs_en = 1'b1;
        startup_check("restart");

        // Real fall landing exactly on the timeout cycle: one event, not lost.
        vs_en = 1'b0;
        repeat (5) tick();
        cfg_req_i = 8'h33;
        repeat (101) tick();
        check("collision pre cfg_applied", cfg_applied_o, 8'h00);
        force_low = 1'b1;
        tick();
        force_low = 1'b0;
        check("collision cfg_applied", cfg_applied_o, 8'h33);
        check("collision vsync_lost", vsync_lost_o, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            vdata_valid_i = ($urandom_range(0, 7) != 0);
            sync_lo       = 3'($urandom);
            if ($urandom_range(0, 39) == 0) cfg_req_i = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) vs_en = !vs_en;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
